// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
//  Shared definitions for the MEM-stage access unit: access-size encodings,
//  FSM state encodings, the default acknowledge timeout and the alignment
//  rule used to decide whether an access may be issued at all.
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

    // Access size as delivered by the EX/MEM register (2'b11 behaves as word)
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    // Access FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEF_ACK_TIMEOUT = 16;

    // Natural alignment: words on 4-byte, halves on 2-byte boundaries
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_HALF: return ~addr_lo[0];
            SIZE_BYTE: return 1'b1;
            default:   return (addr_lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
//  Combinational big-endian byte-lane steering.
//  Ports:
//    size       in  2   access size encoding
//    addr_lo    in  2   byte offset within the word
//    wr_data    in  32  right-justified store data
//    rd_word    in  32  word returned by memory
//    be         out 4   byte enables, bit3 = bits[31:24] (byte 0)
//    wdata      out 32  store data replicated across all lanes
//    load_data  out 32  selected lane, sign-extended for byte/half
// ---------------------------------------------------------------------------
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        // Byte 0 lives in the most significant lane
        case (addr_lo)
            2'd0:    byte_sel = rd_word[31:24];
            2'd1:    byte_sel = rd_word[23:16];
            2'd2:    byte_sel = rd_word[15:8];
            default: byte_sel = rd_word[7:0];
        endcase
        half_sel = addr_lo[1] ? rd_word[15:0] : rd_word[31:16];

        case (size)
            SIZE_BYTE: begin
                be        = 4'b1000 >> addr_lo;
                wdata     = {4{wr_data[7:0]}};
                load_data = {{24{byte_sel[7]}}, byte_sel};
            end
            SIZE_HALF: begin
                be        = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata     = {2{wr_data[15:0]}};
                load_data = {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                be        = 4'b1111;
                wdata     = wr_data;
                load_data = rd_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//  MEM-stage load/store engine talking to a variable-latency data memory over
//  a req/ack handshake. Stalls the upstream pipeline while an access is
//  outstanding, rejects misaligned accesses and abandons accesses that are not
//  acknowledged within ACK_TIMEOUT cycles.
//  Ports:
//    Clk, Reset                      clock, synchronous active-high reset
//    MemRead_in_MEM/MemWrite_in_MEM  load / store request (store wins)
//    size_in_MEM                     00 word, 01 half, 10 byte, 11 word
//    ALUResult_MEM, WriteData_MEM    byte address, right-justified store data
//    mem_req/mem_we/mem_addr/mem_be/mem_wdata   registered memory request
//    mem_rdata, mem_ack              memory response (ack is one cycle)
//    ReadData_MEM                    extended load result, held between loads
//    Stall_MEM                       freeze upstream pipeline registers
//    Misaligned_MEM, Timeout_MEM     single-cycle event pulses
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int CNT_W       = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead_in_MEM,
    input  logic        MemWrite_in_MEM,
    input  logic [1:0]  size_in_MEM,
    input  logic [31:0] ALUResult_MEM,
    input  logic [31:0] WriteData_MEM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] ReadData_MEM,
    output logic        Stall_MEM,
    output logic        Misaligned_MEM,
    output logic        Timeout_MEM
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size_q;
    logic [1:0]       addr_lo_q;
    logic             load_q;

    logic             access;
    logic             aligned;
    logic             issue;
    logic             at_limit;
    logic [1:0]       align_size;
    logic [1:0]       align_lo;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic [31:0]      load_c;

    assign access   = MemRead_in_MEM | MemWrite_in_MEM;
    assign aligned  = is_aligned(size_in_MEM, ALUResult_MEM[1:0]);
    assign issue    = (state == ST_IDLE) & access & aligned;
    assign at_limit = (cnt == CNT_W'(ACK_TIMEOUT - 1));

    // Event outputs are suppressed while reset is held so every output reads 0
    assign Stall_MEM      = ~Reset & (issue | (state == ST_BUSY));
    assign Misaligned_MEM = ~Reset & (state == ST_IDLE) & access & ~aligned;
    assign Timeout_MEM    = ~Reset & (state == ST_BUSY) & ~mem_ack & at_limit;

    // The lane logic builds the request from live inputs while idle and
    // extracts load data using the size/offset captured at issue while busy.
    assign align_size = (state == ST_IDLE) ? size_in_MEM        : size_q;
    assign align_lo   = (state == ST_IDLE) ? ALUResult_MEM[1:0] : addr_lo_q;

    mem_lane_align u_lane (
        .size      (align_size),
        .addr_lo   (align_lo),
        .wr_data   (WriteData_MEM),
        .rd_word   (mem_rdata),
        .be        (be_c),
        .wdata     (wdata_c),
        .load_data (load_c)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            size_q       <= 2'b00;
            addr_lo_q    <= 2'b00;
            load_q       <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            ReadData_MEM <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state     <= ST_BUSY;
                        cnt       <= '0;
                        size_q    <= size_in_MEM;
                        addr_lo_q <= ALUResult_MEM[1:0];
                        load_q    <= ~MemWrite_in_MEM;
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite_in_MEM;
                        mem_addr  <= {ALUResult_MEM[31:2], 2'b00};
                        mem_be    <= be_c;
                        mem_wdata <= wdata_c;
                    end
                end
                ST_BUSY: begin
                    // Ack takes priority over a timeout landing in the same cycle
                    if (mem_ack || at_limit) begin
                        state     <= ST_DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        if (load_q)
                            ReadData_MEM <= mem_ack ? load_c : 32'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // DONE lets the pipeline advance; the instruction still sitting
                // in EX/MEM this cycle has already been serviced.
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int T = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MemRead_in_MEM, MemWrite_in_MEM;
    logic [1:0]  size_in_MEM;
    logic [31:0] ALUResult_MEM, WriteData_MEM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [31:0] ReadData_MEM;
    logic        Stall_MEM, Misaligned_MEM, Timeout_MEM;

    always #5 Clk = ~Clk;

    mem_access_unit #(.ACK_TIMEOUT(T), .CNT_W(5)) dut (
        .Clk(Clk), .Reset(Reset),
        .MemRead_in_MEM(MemRead_in_MEM), .MemWrite_in_MEM(MemWrite_in_MEM),
        .size_in_MEM(size_in_MEM), .ALUResult_MEM(ALUResult_MEM), .WriteData_MEM(WriteData_MEM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ReadData_MEM(ReadData_MEM), .Stall_MEM(Stall_MEM),
        .Misaligned_MEM(Misaligned_MEM), .Timeout_MEM(Timeout_MEM)
    );

    // Expected per-cycle outputs
    logic        e_req, e_we, e_stall, e_mis, e_to;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [3:0]  e_be;
    logic        chk_en = 1'b0;

    int n_vec = 0, n_bad = 0;
    int stall_cyc = 0, req_cyc = 0, to_cnt = 0, mis_cnt = 0;
    logic        last_we;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("mem_req",        32'(mem_req),        32'(e_req));
            chk("mem_we",         32'(mem_we),         32'(e_we));
            chk("mem_addr",       mem_addr,            e_addr);
            chk("mem_be",         32'(mem_be),         32'(e_be));
            chk("mem_wdata",      mem_wdata,           e_wdata);
            chk("ReadData_MEM",   ReadData_MEM,        e_rd);
            chk("Stall_MEM",      32'(Stall_MEM),      32'(e_stall));
            chk("Misaligned_MEM", 32'(Misaligned_MEM), 32'(e_mis));
            chk("Timeout_MEM",    32'(Timeout_MEM),    32'(e_to));
            if (Stall_MEM)      stall_cyc++;
            if (Timeout_MEM)    to_cnt++;
            if (Misaligned_MEM) mis_cnt++;
            if (mem_req) begin
                req_cyc++;
                last_we = mem_we; last_addr = mem_addr; last_be = mem_be; last_wdata = mem_wdata;
            end
        end
    end

    // ---------------- reference model (arithmetic view of the rules) ----------------
    function automatic logic m_aligned(input int sz, input logic [31:0] a);
        if (sz == 2) return 1'b1;
        if (sz == 1) return (a % 2) == 0;
        return (a % 4) == 0;
    endfunction

    function automatic logic [3:0] m_be(input int sz, input logic [31:0] a);
        int lo = int'(a % 4);
        if (sz == 2) return 4'(1 << (3 - lo));
        if (sz == 1) return (lo < 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] wd);
        if (sz == 2) return (wd & 32'hFF)   * 32'h01010101;
        if (sz == 1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_extract(input int sz, input logic [31:0] a, input logic [31:0] w);
        int lo = int'(a % 4);
        int v;
        if (sz == 2) begin
            v = int'((w >> (8 * (3 - lo))) & 32'hFF);
            if (v >= 128) v -= 256;
            return 32'(v);
        end
        if (sz == 1) begin
            v = int'((w >> (16 * (1 - lo / 2))) & 32'hFFFF);
            if (v >= 32768) v -= 65536;
            return 32'(v);
        end
        return w;
    endfunction

    task automatic set_idle_exp();
        e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
        e_stall = 0; e_mis = 0; e_to = 0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One instruction presented to the MEM stage; ack_at = BUSY cycle index that
    // carries mem_ack (values outside 1..T mean memory never answers).
    task automatic do_access(input logic rd, input logic wr, input int sz, input logic [31:0] a,
                             input logic [31:0] wd, input int ack_at, input logic [31:0] rdat);
        logic acked;
        MemRead_in_MEM = rd; MemWrite_in_MEM = wr; size_in_MEM = 2'(sz);
        ALUResult_MEM = a; WriteData_MEM = wd; mem_ack = 0;
        set_idle_exp();
        if (!(rd | wr) || !m_aligned(sz, a)) begin
            e_mis = rd | wr;
            tick();
            return;
        end
        e_stall = 1;
        tick();
        acked = 0;
        for (int k = 1; k <= T; k++) begin
            e_req = 1; e_we = wr; e_addr = a & 32'hFFFFFFFC;
            e_be = m_be(sz, a); e_wdata = m_wdata(sz, wd); e_stall = 1;
            if (k == ack_at) begin
                mem_ack = 1; mem_rdata = rdat; acked = 1; e_to = 0;
            end else begin
                mem_ack = 0; mem_rdata = $urandom; e_to = (k == T);
            end
            tick();
            if (acked) break;
        end
        mem_ack = 0; mem_rdata = $urandom;
        set_idle_exp();
        if (!wr) e_rd = acked ? m_extract(sz, a, rdat) : 32'h0;
        tick();
    endtask

    task automatic idle(input int n);
        MemRead_in_MEM = 0; MemWrite_in_MEM = 0;
        set_idle_exp();
        for (int i = 0; i < n; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            tick();
        end
        mem_ack = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1; MemRead_in_MEM = 0; MemWrite_in_MEM = 0; size_in_MEM = 0;
        ALUResult_MEM = 0; WriteData_MEM = 0; mem_rdata = 0; mem_ack = 0;
        set_idle_exp(); e_rd = 0;
        tick();
        chk_en = 1;
        tick(); tick();
        chk("rst_readdata", ReadData_MEM, 32'h0);
        Reset = 0;
        tick();

        // lw 0x100, ack in 3rd BUSY cycle
        stall_cyc = 0;
        do_access(1, 0, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        chk("lw_stall_cycles", 32'(stall_cyc), 32'd4);
        chk("lw_addr", last_addr, 32'h100);
        chk("lw_be", 32'(last_be), 32'hF);
        chk("lw_readdata", ReadData_MEM, 32'hDEADBEEF);

        // lb 0x103 with ack in 1st BUSY cycle
        stall_cyc = 0;
        do_access(1, 0, 2, 32'h103, 32'h0, 1, 32'h123456F0);
        chk("lb_stall_cycles", 32'(stall_cyc), 32'd2);
        chk("lb_be", 32'(last_be), 32'h1);
        chk("lb_neg_readdata", ReadData_MEM, 32'hFFFFFFF0);
        do_access(1, 0, 2, 32'h101, 32'h0, 2, 32'h127F0000);
        chk("lb_pos_readdata", ReadData_MEM, 32'h0000007F);

        // sh 0x202
        do_access(0, 1, 1, 32'h202, 32'h0000ABCD, 2, 32'hFFFFFFFF);
        chk("sh_we", 32'(last_we), 32'h1);
        chk("sh_addr", last_addr, 32'h200);
        chk("sh_be", 32'(last_be), 32'h3);
        chk("sh_wdata", last_wdata, 32'hABCDABCD);
        chk("sh_readdata_kept", ReadData_MEM, 32'h0000007F);

        // misaligned lh / lw
        mis_cnt = 0; req_cyc = 0; stall_cyc = 0;
        do_access(1, 0, 1, 32'h101, 32'h0, 1, 32'h0);
        do_access(1, 0, 0, 32'h102, 32'h0, 1, 32'h0);
        idle(1);
        chk("misaligned_pulses", 32'(mis_cnt), 32'd2);
        chk("misaligned_no_req", 32'(req_cyc), 32'd0);
        chk("misaligned_no_stall", 32'(stall_cyc), 32'd0);

        // lw never acknowledged
        req_cyc = 0; to_cnt = 0;
        do_access(1, 0, 0, 32'h400, 32'h0, 0, 32'h0);
        chk("timeout_req_cycles", 32'(req_cyc), 32'(T));
        chk("timeout_pulses", 32'(to_cnt), 32'd1);
        chk("timeout_readdata", ReadData_MEM, 32'h0);

        // ack on the very cycle the counter hits its limit
        to_cnt = 0;
        do_access(1, 0, 0, 32'h404, 32'h0, T, 32'h0BADF00D);
        chk("ack_at_limit_no_timeout", 32'(to_cnt), 32'd0);
        chk("ack_at_limit_readdata", ReadData_MEM, 32'h0BADF00D);

        // reset in 2nd BUSY cycle, stray ack afterwards
        MemRead_in_MEM = 1; MemWrite_in_MEM = 0; size_in_MEM = 0;
        ALUResult_MEM = 32'h300; WriteData_MEM = 32'h0;
        set_idle_exp(); e_stall = 1;
        tick();
        e_req = 1; e_addr = 32'h300; e_be = 4'hF; e_wdata = 32'h0; e_stall = 1;
        tick();
        Reset = 1; MemRead_in_MEM = 0; e_stall = 0;
        tick();
        Reset = 0; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        set_idle_exp(); e_rd = 0;
        stall_cyc = 0; req_cyc = 0;
        tick();
        mem_ack = 0;
        tick();
        chk("reset_mid_readdata", ReadData_MEM, 32'h0);
        chk("reset_mid_no_req", 32'(req_cyc), 32'd0);
        chk("reset_mid_no_stall", 32'(stall_cyc), 32'd0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            int r;
            logic rd, wr;
            r = int'($urandom_range(0, 7));
            rd = (r == 1) || (r >= 2 && r <= 4);
            wr = (r == 1) || (r >= 5);
            do_access(rd, wr, int'($urandom_range(0, 3)), $urandom, $urandom,
                      int'($urandom_range(0, T + 3)), $urandom);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(2);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
